// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: FSM state encoding, NOP encoding and the load-use detect helper
package hazard_ctrl_pkg;
    typedef enum logic [1:0] {RUN = 2'd0, BUBBLE = 2'd1, MEM_WAIT = 2'd2, ERROR = 2'd3} state_t;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;
    function automatic logic load_use(input logic [4:0] rs1, rs2, rd, input logic mem_read);
        return mem_read && rd != 5'd0 && (rd == rs1 || rd == rs2);
    endfunction
endpackage

// File: rtl/hazard_control_unit_if.sv
// hazard_control_unit_if: ID-stage operands, memory handshake in; pipe enables, flush, stall, timeout out
// master drives operands/handshake, slave (the unit) drives the pipeline controls;
// HAZARD_PERF_CNT_EN adds Stall_Cycles/Flush_Count.
interface hazard_control_unit_if;
    logic [4:0] ID_RS1, ID_RS2, ID_EX_RD;
    logic       ID_EX_MemRead, Branch_Taken, Dmem_Req, Dmem_Ready;
    logic       PC_Write, IF_ID_Write, NoOp, IF_ID_Flush, Pipe_Stall, Err_Timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] Stall_Cycles;
    logic [15:0] Flush_Count;
    modport master (output ID_RS1, ID_RS2, ID_EX_RD, ID_EX_MemRead, Branch_Taken, Dmem_Req, Dmem_Ready,
                    input PC_Write, IF_ID_Write, NoOp, IF_ID_Flush, Pipe_Stall, Err_Timeout, Stall_Cycles, Flush_Count);
    modport slave (input ID_RS1, ID_RS2, ID_EX_RD, ID_EX_MemRead, Branch_Taken, Dmem_Req, Dmem_Ready,
                   output PC_Write, IF_ID_Write, NoOp, IF_ID_Flush, Pipe_Stall, Err_Timeout, Stall_Cycles, Flush_Count);
`else
    modport master (output ID_RS1, ID_RS2, ID_EX_RD, ID_EX_MemRead, Branch_Taken, Dmem_Req, Dmem_Ready,
                    input PC_Write, IF_ID_Write, NoOp, IF_ID_Flush, Pipe_Stall, Err_Timeout);
    modport slave (input ID_RS1, ID_RS2, ID_EX_RD, ID_EX_MemRead, Branch_Taken, Dmem_Req, Dmem_Ready,
                   output PC_Write, IF_ID_Write, NoOp, IF_ID_Flush, Pipe_Stall, Err_Timeout);
`endif
endinterface

// File: rtl/hazard_control_unit_wait_timer.sv
// hazard_wait_timer: saturating memory-wait counter; i_clr zeroes, i_en counts, o_hit flags MAX_WAIT
module hazard_wait_timer #(
    parameter int MAX_WAIT = 64,
    localparam int W = $clog2(MAX_WAIT + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_clr,
    input  logic i_en,
    output logic o_hit
);
    logic [W-1:0] r_cnt;
    assign o_hit = r_cnt == W'(MAX_WAIT);
    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) r_cnt <= '0;
        else if (i_clr) r_cnt <= '0;
        else if (i_en && !o_hit) r_cnt <= r_cnt + 1'b1;
endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: load-use bubbles, branch flush, memory-wait freeze and timeout sequencer
// clk_i/rst_i (async, active-low) plus bus (slave modport); optional HAZARD_PERF_CNT_EN adds
// saturating Stall_Cycles/Flush_Count.
module hazard_control_unit
    import hazard_ctrl_pkg::*;
#(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int MAX_WAIT = 64
) (
    input logic clk_i,
    input logic rst_i,
    hazard_control_unit_if.slave bus
);
    state_t     r_state, w_next;
    logic [1:0] r_bub, w_bub_next, r_saved, w_saved_next;
    logic       w_hz, w_mw, w_hit, w_clr, w_en;
    logic       w_pc, w_ifid, w_noop, w_flush, w_stall, w_err;
    assign w_hz = load_use(bus.ID_RS1, bus.ID_RS2, bus.ID_EX_RD, bus.ID_EX_MemRead);
    assign w_mw = bus.Dmem_Req && !bus.Dmem_Ready;
    hazard_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
        .clk_i(clk_i), .rst_i(rst_i), .i_clr(w_clr), .i_en(w_en), .o_hit(w_hit)
    );
    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
            r_state <= RUN;
            r_bub   <= '0;
            r_saved <= '0;
        end else begin
            r_state <= w_next;
            r_bub   <= w_bub_next;
            r_saved <= w_saved_next;
        end
    always_comb begin
        w_next = r_state;
        w_bub_next = r_bub;
        w_saved_next = r_saved;
        w_pc = 1'b1;
        w_ifid = 1'b1;
        w_noop = 1'b0;
        w_flush = 1'b0;
        w_stall = 1'b0;
        w_err = 1'b0;
        w_clr = 1'b0;
        w_en = 1'b0;
        case (r_state)
            RUN, BUBBLE:
                if (w_mw) begin
                    // a wait interrupting a bubble parks the remaining bubble count
                    {w_pc, w_ifid, w_stall} = 3'b001;
                    w_next = MEM_WAIT;
                    w_en = 1'b1;
                    w_saved_next = r_state == BUBBLE ? r_bub : 2'd0;
                end else if (r_state == BUBBLE || w_hz) begin
                    {w_pc, w_ifid, w_noop} = 3'b001;
                    if (r_state == BUBBLE) begin
                        w_bub_next = r_bub - 2'd1;
                        w_next = r_bub == 2'd1 ? RUN : BUBBLE;
                    end else if (LOAD_USE_BUBBLES > 1) begin
                        w_next = BUBBLE;
                        w_bub_next = 2'(LOAD_USE_BUBBLES - 1);
                    end
                end else
                    w_flush = bus.Branch_Taken;
            MEM_WAIT: begin
                {w_pc, w_ifid, w_stall} = 3'b001;
                if (bus.Dmem_Ready) begin
                    w_clr = 1'b1;
                    w_next = r_saved != 2'd0 ? BUBBLE : RUN;
                    w_bub_next = r_saved;
                    w_saved_next = 2'd0;
                end else if (w_hit)
                    w_next = ERROR;
                else
                    w_en = 1'b1;
            end
            ERROR: begin
                {w_pc, w_ifid, w_stall} = 3'b001;
                w_err = 1'b1;
            end
        endcase
    end
    assign bus.PC_Write    = rst_i && w_pc;
    assign bus.IF_ID_Write = rst_i && w_ifid;
    assign bus.NoOp        = !rst_i || w_noop;
    assign bus.IF_ID_Flush = rst_i && w_flush;
    assign bus.Pipe_Stall  = rst_i && w_stall;
    assign bus.Err_Timeout = rst_i && w_err;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [15:0] r_flush_count;
    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (!w_pc && r_stall_cycles != '1) r_stall_cycles <= r_stall_cycles + 32'd1;
            if (w_flush && r_flush_count != '1) r_flush_count <= r_flush_count + 16'd1;
        end
    assign bus.Stall_Cycles = r_stall_cycles;
    assign bus.Flush_Count  = r_flush_count;
`endif
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: directed vectors checked by a behavioural model and literal expectations
module tb_hazard_control_unit;
    localparam int LUB = 2;
    localparam int MAXW = 8;
    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    hazard_control_unit_if bus();
    hazard_control_unit #(.LOAD_USE_BUBBLES(LUB), .MAX_WAIT(MAXW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .bus(bus)
    );
    always #5 clk_i = ~clk_i;
    function automatic logic [5:0] outs();
        return {bus.PC_Write, bus.IF_ID_Write, bus.NoOp, bus.IF_ID_Flush, bus.Pipe_Stall, bus.Err_Timeout};
    endfunction
    int m_bub = 0, m_pend = 0, m_wait = 0;
    bit m_waiting = 0, m_dead = 0;
    int unsigned m_stalls = 0, m_flushes = 0;
    always @(negedge clk_i) begin : model
        logic [5:0] e;
        logic hz, mw;
        hz = bus.ID_EX_MemRead && bus.ID_EX_RD != 5'd0 &&
             (bus.ID_EX_RD == bus.ID_RS1 || bus.ID_EX_RD == bus.ID_RS2);
        mw = bus.Dmem_Req && !bus.Dmem_Ready;
        if (!rst_i) begin
            e = 6'b001000;
            m_bub = 0; m_pend = 0; m_wait = 0; m_waiting = 0; m_dead = 0;
        end else if (m_dead)
            e = 6'b000011;
        else if (m_waiting) begin
            e = 6'b000010;
            if (bus.Dmem_Ready) begin
                m_waiting = 0; m_bub = m_pend; m_pend = 0;
            end else if (m_wait == MAXW)
                m_dead = 1;
            else
                m_wait++;
        end else if (mw) begin
            e = 6'b000010;
            m_waiting = 1; m_wait = 1; m_pend = m_bub; m_bub = 0;
        end else if (m_bub > 0) begin
            e = 6'b001000;
            m_bub--;
        end else if (hz) begin
            e = 6'b001000;
            m_bub = LUB - 1;
        end else
            e = bus.Branch_Taken ? 6'b110100 : 6'b110000;
        n_chk++;
        if (outs() !== e) begin
            n_fail++;
            $display("FAIL model t=%0t outs(pc,ifid,noop,flush,stall,err) got %b expected %b", $time, outs(), e);
        end
`ifdef HAZARD_PERF_CNT_EN
        if (!rst_i) begin
            m_stalls = 0; m_flushes = 0;
        end
        n_chk++;
        if (bus.Stall_Cycles !== m_stalls || bus.Flush_Count !== 16'(m_flushes)) begin
            n_fail++;
            $display("FAIL perf t=%0t stall/flush got %0d/%0d expected %0d/%0d", $time,
                     bus.Stall_Cycles, bus.Flush_Count, m_stalls, m_flushes);
        end
        if (rst_i && !e[5]) m_stalls++;
        if (rst_i && e[2]) m_flushes++;
`endif
    end
    task automatic drive(input logic [4:0] rs1, rs2, rd, input logic mr, br, req, rdy);
        @(posedge clk_i);
        #1;
        bus.ID_RS1 = rs1; bus.ID_RS2 = rs2; bus.ID_EX_RD = rd;
        bus.ID_EX_MemRead = mr; bus.Branch_Taken = br; bus.Dmem_Req = req; bus.Dmem_Ready = rdy;
    endtask
    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic chk(input string nm, input logic [5:0] e);
        @(negedge clk_i);
        n_chk++;
        if (outs() !== e) begin
            n_fail++;
            $display("FAIL %s outs(pc,ifid,noop,flush,stall,err) got %b expected %b", nm, outs(), e);
        end
    endtask
    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            chk("reset_hold", 6'b001000);
        end
        idle(); rst_i = 1'b1;
        chk("after_reset", 6'b110000);
        drive(0, 5, 5, 1, 0, 0, 0); chk("load_use_1", 6'b001000);
        drive(0, 5, 5, 1, 0, 0, 0); chk("load_use_2", 6'b001000);
        idle(); chk("load_use_done", 6'b110000);
        drive(0, 0, 0, 1, 0, 0, 0); chk("rd_zero", 6'b110000);
        drive(7, 0, 7, 1, 1, 0, 0); chk("branch_hz", 6'b001000);
        drive(0, 0, 0, 0, 1, 0, 0); chk("branch_in_bubble", 6'b001000);
        drive(0, 0, 0, 0, 1, 0, 0); chk("branch_flush", 6'b110100);
        idle(); chk("branch_done", 6'b110000);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 1, 0); chk("mem_wait", 6'b000010);
        end
        drive(0, 0, 0, 0, 0, 1, 1); chk("mem_ready", 6'b000010);
        idle(); chk("mem_done", 6'b110000);
        drive(0, 5, 5, 1, 0, 0, 0); chk("bub_wait_hz", 6'b001000);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 1, 0); chk("bub_wait", 6'b000010);
        end
        drive(0, 0, 0, 0, 0, 1, 1); chk("bub_wait_ready", 6'b000010);
        idle(); chk("bub_resumed", 6'b001000);
        idle(); chk("bub_resume_done", 6'b110000);
        for (int i = 0; i < MAXW; i++) begin
            drive(0, 0, 0, 0, 0, 1, 0); chk("limit_wait", 6'b000010);
        end
        drive(0, 0, 0, 0, 0, 1, 1); chk("ready_at_limit", 6'b000010);
        idle(); chk("no_timeout", 6'b110000);
        for (int i = 0; i < MAXW + 1; i++) begin
            drive(0, 0, 0, 0, 0, 1, 0); chk("timeout_wait", 6'b000010);
        end
        drive(0, 0, 0, 0, 0, 1, 1); chk("timeout_err", 6'b000011);
        drive(3, 3, 3, 1, 1, 0, 0); chk("error_sticky", 6'b000011);
        idle(); chk("error_sticky_idle", 6'b000011);
        idle(); rst_i = 1'b0; chk("reset_in_error", 6'b001000);
        idle(); rst_i = 1'b1; chk("error_cleared", 6'b110000);
        drive(0, 9, 9, 1, 0, 0, 0); chk("hz_before_reset", 6'b001000);
        idle(); rst_i = 1'b0; chk("reset_in_bubble", 6'b001000);
        idle(); rst_i = 1'b1; chk("no_bubble_survives", 6'b110000);
        drive(4, 0, 4, 1, 0, 0, 0); chk("perf_lu", 6'b001000);
        drive(0, 0, 0, 0, 0, 0, 0); chk("perf_lu_b", 6'b001000);
        drive(0, 0, 0, 0, 1, 0, 0); chk("perf_flush_1", 6'b110100);
        drive(0, 0, 0, 0, 1, 0, 0); chk("perf_flush_2", 6'b110100);
        idle(); idle();
        @(negedge clk_i);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
